// File: rtl/chimp_pkg.sv
// Shared chimp-test grid geometry, pixel/colour types and the painter state
// encoding, so the click decoder and the box painter always agree on layout.
package chimp_pkg;

    localparam int unsigned X_ORIGIN = 17;
    localparam int unsigned X_PITCH  = 37;
    localparam int unsigned Y_ORIGIN = 8;
    localparam int unsigned Y_PITCH  = 28;
    localparam int unsigned BOX_W    = 20;
    localparam int unsigned BOX_H    = 20;
    localparam int unsigned GRID_N   = 8;
    localparam int unsigned COLOUR_W = 3;
    localparam int unsigned CNT_W    = 5;

    typedef logic [2:0]          box_idx_t;
    typedef logic [9:0]          pix_x_t;
    typedef logic [8:0]          pix_y_t;
    typedef logic [COLOUR_W-1:0] colour_t;
    typedef logic [CNT_W-1:0]    cnt_t;

    localparam colour_t BORDER_COLOUR = 3'b111;
    localparam cnt_t    CX_LAST       = cnt_t'(BOX_W - 1);
    localparam cnt_t    CY_LAST       = cnt_t'(BOX_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAW,
        ST_DONE
    } painter_state_t;

    // Constant multiplies reduce to shift-add; 7*37+17 = 276 fits in 10 bits.
    function automatic pix_x_t box_base_x(box_idx_t idx);
        return pix_x_t'(X_ORIGIN) + pix_x_t'(X_PITCH) * pix_x_t'(idx);
    endfunction

    function automatic pix_y_t box_base_y(box_idx_t idx);
        return pix_y_t'(Y_ORIGIN) + pix_y_t'(Y_PITCH) * pix_y_t'(idx);
    endfunction

endpackage

// File: rtl/chimp_box_origin.sv
// Registered box-index to top-left-pixel mapper; loads on iLoad and holds.
// Reusable by any renderer that needs a box origin (e.g. cursor highlight).
module chimp_box_origin
    import chimp_pkg::*;
(
    input  logic       clk,
    input  logic       iReset,
    input  logic       iLoad,
    input  logic [2:0] iBoxX,
    input  logic [2:0] iBoxY,
    output logic [9:0] oBaseX,
    output logic [8:0] oBaseY
);

    pix_x_t base_x_q, base_x_d;
    pix_y_t base_y_q, base_y_d;

    always_comb begin
        base_x_d = base_x_q;
        base_y_d = base_y_q;
        if (iLoad) begin
            base_x_d = box_base_x(iBoxX);
            base_y_d = box_base_y(iBoxY);
        end
    end

    always_ff @(posedge clk or negedge iReset) begin
        if (!iReset) begin
            base_x_q <= '0;
            base_y_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
        end
    end

    assign oBaseX = base_x_q;
    assign oBaseY = base_y_q;

endmodule

// File: rtl/chimp_box_painter.sv
// Walks every pixel of one chimp-grid box row-major and streams stallable
// framebuffer writes. Define CHIMP_BOX_BORDER_EN to paint the outline in BORDER_COLOUR.
module chimp_box_painter
    import chimp_pkg::*;
(
    input  logic                clk,
    input  logic                iReset,
    input  logic                iStart,
    input  logic [2:0]          iBoxX,
    input  logic [2:0]          iBoxY,
    input  logic [COLOUR_W-1:0] iColour,
    input  logic                iReady,
    output logic [9:0]          oX,
    output logic [8:0]          oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oDone
);

    painter_state_t state_q, state_d;
    cnt_t           cx_q, cx_d, cy_q, cy_d;
    colour_t        fill_q, fill_d;
    pix_x_t         x_q, x_d;
    pix_y_t         y_q, y_d;
    colour_t        colour_q, colour_d;
    logic           plot_q, plot_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           start_ok;
    pix_x_t         base_x;
    pix_y_t         base_y;
    colour_t        colour_next;
`ifdef CHIMP_BOX_BORDER_EN
    logic           on_border;
`endif

    assign start_ok = (state_q == ST_IDLE) && iStart;

    chimp_box_origin u_origin (
        .clk    (clk),
        .iReset (iReset),
        .iLoad  (start_ok),
        .iBoxX  (iBoxX),
        .iBoxY  (iBoxY),
        .oBaseX (base_x),
        .oBaseY (base_y)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        fill_d   = fill_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = plot_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    fill_d  = iColour;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cx_d    = '0;
                cy_d    = '0;
                plot_d  = 1'b1;
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                // A stalled write holds every output and counter untouched.
                if (iReady) begin
                    if (cx_q == CX_LAST) begin
                        cx_d = '0;
                        if (cy_q == CY_LAST) begin
                            plot_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            cy_d = cy_q + cnt_t'(1);
                        end
                    end else begin
                        cx_d = cx_q + cnt_t'(1);
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef CHIMP_BOX_BORDER_EN
        on_border   = (cx_d == '0) || (cx_d == CX_LAST) || (cy_d == '0) || (cy_d == CY_LAST);
        colour_next = on_border ? BORDER_COLOUR : fill_q;
`else
        colour_next = fill_q;
`endif

        // Pixel outputs are re-derived whenever a new write is presented.
        if (plot_d && (state_q == ST_LOAD || (state_q == ST_DRAW && iReady))) begin
            x_d      = base_x + pix_x_t'(cx_d);
            y_d      = base_y + pix_y_t'(cy_d);
            colour_d = colour_next;
        end
    end

    always_ff @(posedge clk or negedge iReset) begin
        if (!iReset) begin
            state_q  <= ST_IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            fill_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            fill_q   <= fill_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign oX      = x_q;
    assign oY      = y_q;
    assign oColour = colour_q;
    assign oPlot   = plot_q;
    assign oBusy   = busy_q;
    assign oDone   = done_q;

endmodule

// File: doc/chimp_box_painter.md
Name: chimp_box_painter

Overview:
- Inverse of the mouse hit-test for the chimp-test grid: takes a box index (BoxX, BoxY in 0..7) and a colour, and walks every pixel of that box.
- Emits one framebuffer write (x, y, colour) per accepted cycle, using the same 8x8 grid geometry as the click decoder.
- Sits between the chimp game FSM, which requests box fills and clears, and the shared VGA framebuffer write port, which can stall via a ready signal.

Parameters:
- X_ORIGIN, 17, pixel x of the left edge of column 0.
- X_PITCH, 37, horizontal distance between column left edges.
- Y_ORIGIN, 8, pixel y of the top edge of row 0.
- Y_PITCH, 28, vertical distance between row top edges.
- BOX_W, 20, box width in pixels.
- BOX_H, 20, box height in pixels.
- COLOUR_W, 3, colour word width.
- BORDER_COLOUR, 3'b111, outline colour; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- iReset  in  1  asynchronous, active-low reset.
- iStart  in  1  request pulse; sampled only in IDLE.
- iBoxX  in  3  column index, captured on an accepted iStart.
- iBoxY  in  3  row index, captured on an accepted iStart.
- iColour  in  COLOUR_W  fill colour, captured on an accepted iStart.
- iReady  in  1  framebuffer accepts a write this cycle.
- oX  out  10  pixel x of the current write.
- oY  out  9  pixel y of the current write.
- oColour  out  COLOUR_W  colour of the current write.
- oPlot  out  1  write valid.
- oBusy  out  1  high from LOAD through DONE inclusive.
- oDone  out  1  one-cycle completion pulse.

Behaviour:
- Reset (iReset=0, async): state IDLE; oX=0, oY=0, oColour=0, oPlot=0, oBusy=0, oDone=0; internal counters and captured index cleared.
- Reset mid-draw aborts immediately. No oDone is issued, and the box is left partially painted.
- States: IDLE -> LOAD -> DRAW -> DONE -> IDLE.
- IDLE:
  - iStart=1 captures iBoxX, iBoxY and iColour, then moves to LOAD.
  - iStart while not IDLE is ignored; there is no queueing.
- LOAD (1 cycle):
  - baseX = X_ORIGIN + X_PITCH*boxX, computed at 10 bits.
  - baseY = Y_ORIGIN + Y_PITCH*boxY, computed at 9 bits.
  - Use registered constant multiply or shift-add, no DSP needed.
  - Column counter cx=0, row counter cy=0. Go to DRAW.
- DRAW:
  - oPlot=1, oX=baseX+cx, oY=baseY+cy, oColour=captured colour.
  - Outputs are registered and valid in the same cycle oPlot is high.
- Handshake:
  - A write completes on a cycle with oPlot=1 and iReady=1.
  - While iReady=0, oX, oY, oColour and oPlot hold stable and the counters do not advance.
- Scan order is row-major:
  - cx increments per completed write.
  - At cx=BOX_W-1, cx wraps to 0 and cy increments.
  - The completed write at cx=BOX_W-1, cy=BOX_H-1 moves to DONE, with oPlot=0 in the following cycle.
- Write count is exactly BOX_W*BOX_H = 400 per request, with no duplicates and no gaps.
- Latency: first oPlot occurs 2 cycles after the accepted iStart (IDLE->LOAD->DRAW). With iReady held high, oDone occurs 402 cycles after iStart.
- DONE (1 cycle): oDone=1, oPlot=0, oBusy=1, then return to IDLE. iStart is accepted again the cycle after DONE.
- iReady is a don't-care outside DRAW.
- Index 7 must not overflow: max x = 17+259+19 = 295 and max y = 8+196+19 = 223.

Optional Feature:
- Macro: CHIMP_BOX_BORDER_EN.
- Defined: writes where cx==0, cx==BOX_W-1, cy==0 or cy==BOX_H-1 use BORDER_COLOUR; interior writes use the captured colour. Write count, order and timing are unchanged.
- Undefined: every write uses the captured colour, and BORDER_COLOUR is unused.

Decomposition:
- Shared package chimp_pkg holds:
  - grid constants X_ORIGIN, X_PITCH, Y_ORIGIN, Y_PITCH, BOX_W, BOX_H and GRID_N=8;
  - typedef box_idx_t (3-bit), pix_x_t (10-bit), pix_y_t (9-bit), colour_t;
  - the painter state enum.
- The click decoder and the painter both take geometry from chimp_pkg so the two ends always agree.
- One sub-module, chimp_box_origin: a registered index-to-base-pixel mapper (box_idx -> baseX/baseY), reusable for a cursor-highlight renderer.

Test Plan:
- Box (0,0), colour 3'b010, iReady=1:
  - first write (17,8), last write (36,27);
  - 400 writes, oDone at cycle 402.
- Box (7,7): first write (276,204), last (295,223); every coordinate inside the decoder's accept window, so mouse round-trip decodes to (7,7).
- Box (3,5) with iReady toggling 1,0,0,1:
  - outputs held stable while iReady=0;
  - still exactly 400 unique writes, row-major.
- iStart pulsed mid-draw with box (1,1): ignored; the original box (3,5) completes, with one oDone and oBusy continuously high.
- iReset asserted after 150 writes: oPlot, oBusy and oDone drop to 0 asynchronously with no oDone; a new iStart after release draws cleanly from cx=cy=0.
- CHIMP_BOX_BORDER_EN defined, box (2,2):
  - writes at (91,64) and (110,83) use BORDER_COLOUR;
  - (92,65) uses iColour;
  - 76 border writes and 324 interior writes.
